// File: rtl/video_system_keycode_pkg.sv
// video_system_keycode_pkg: register map and bit positions shared by the keycode FIFO PIO.
package video_system_keycode_pkg;
    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_FIFO    = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_IRQMASK = 3'd3;
    localparam int ST_EMPTY       = 16;
    localparam int ST_FULL        = 17;
    localparam int ST_OVF         = 18;
    localparam int FIFO_VALID_BIT = 31;
endpackage

// File: rtl/keycode_sync_fifo.sv
// keycode_sync_fifo: synchronous FIFO; a pop frees space for a push on the same edge when full.
module keycode_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == FULL_CNT;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rp];
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
endmodule

// File: rtl/video_system_keycode_fifo_pio.sv
// video_system_keycode_fifo_pio: Avalon-MM keycode PIO that queues every change of in_port.
// Define KEYCODE_IRQ_EN to build the IRQMASK register and the level interrupt.
module video_system_keycode_fifo_pio #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int PUSH_ZERO   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port,
    output logic              irq
);
    import video_system_keycode_pkg::*;
    logic [DATA_W-1:0] sync_q [SYNC_STAGES];
    logic [DATA_W-1:0] s, prev, head;
    logic [$clog2(DEPTH):0] count;
    logic empty, full, push, pop, rd, wr, overflow, ovf_set, ovf_clr;
    logic [31:0] status_w, mask_rd, rdata;
    logic unused;
    assign s       = sync_q[SYNC_STAGES-1];
    assign push    = (s != prev) && (PUSH_ZERO != 0 || s != '0);
    assign rd      = chipselect && read;
    assign wr      = chipselect && write;
    assign pop     = rd && address == REG_FIFO;
    // A full FIFO only loses the entry when no pop frees a slot on the same edge.
    assign ovf_set = push && full && !pop;
    assign ovf_clr = wr && address == REG_STATUS && writedata[ST_OVF];
    assign unused  = ^writedata;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev     <= '0;
            overflow <= 1'b0;
            readdata <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev     <= s;
            overflow <= ovf_set || (overflow && !ovf_clr);
            if (rd) readdata <= rdata;
        end
    keycode_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .din(s),
        .head(head), .count(count), .empty(empty), .full(full)
    );
    always_comb begin
        status_w           = '0;
        status_w[15:0]     = 16'(count);
        status_w[ST_EMPTY] = empty;
        status_w[ST_FULL]  = full;
        status_w[ST_OVF]   = overflow;
    end
    always_comb
        rdata = (address == REG_DATA)    ? 32'(s) :
                (address == REG_FIFO)    ? (empty ? 32'd0 : (32'(head) | (32'd1 << FIFO_VALID_BIT))) :
                (address == REG_STATUS)  ? status_w :
                (address == REG_IRQMASK) ? mask_rd : 32'd0;
`ifdef KEYCODE_IRQ_EN
    logic [1:0] irq_mask;
    assign mask_rd = {30'd0, irq_mask};
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr && address == REG_IRQMASK) irq_mask <= writedata[1:0];
            irq <= (irq_mask[0] && !empty) || (irq_mask[1] && overflow);
        end
`else
    assign mask_rd = '0;
    assign irq     = 1'b0;
`endif
endmodule

// File: tb/tb_video_system_keycode_fifo_pio.sv
// tb_video_system_keycode_fifo_pio: directed checks of register map, FIFO ordering, overflow, IRQ and reset.
module tb_video_system_keycode_fifo_pio;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [2:0] address = '0;
    logic chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0] in_port = '0;
    logic irq;
    int n_checks = 0;
    int n_fail = 0;

    video_system_keycode_fifo_pio dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a; chipselect = 1'b1; read = 1'b1;
        tick();
        chipselect = 1'b0; read = 1'b0;
        check(tag, readdata, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic set_code(input logic [7:0] v);
        in_port = v;
        repeat (5) tick();
    endtask

    initial begin
        repeat (3) tick();
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        tick();
        rd_chk("reset_data", 3'd0, 32'd0);
        rd_chk("reset_fifo", 3'd1, 32'd0);
        rd_chk("reset_status", 3'd2, 32'h0001_0000);
        rd_chk("reset_irqmask", 3'd3, 32'd0);
        rd_chk("reg4", 3'd4, 32'd0);

        set_code(8'h1C);
        rd_chk("live_data", 3'd0, 32'h0000_001C);
        set_code(8'h00);
        set_code(8'h32);
        rd_chk("pop_1c", 3'd1, 32'h8000_001C);
        rd_chk("pop_32", 3'd1, 32'h8000_0032);
        rd_chk("pop_empty", 3'd1, 32'h0000_0000);

        for (int i = 1; i <= 17; i++) set_code(8'(i));
        rd_chk("ovf_status", 3'd2, 32'h0006_0010);
        for (int i = 1; i <= 16; i++) rd_chk($sformatf("ovf_pop_%0d", i), 3'd1, 32'h8000_0000 | 32'(i));
        rd_chk("drained_status", 3'd2, 32'h0005_0000);
        wr(3'd2, 32'h0004_0000);
        rd_chk("ovf_cleared", 3'd2, 32'h0001_0000);

        for (int i = 0; i < 16; i++) set_code(8'h21 + 8'(i));
        rd_chk("full_status", 3'd2, 32'h0002_0010);
        in_port = 8'h31;
        tick();
        tick();
        rd_chk("full_pushpop", 3'd1, 32'h8000_0021);
        rd_chk("full_pushpop_status", 3'd2, 32'h0002_0010);
        for (int i = 0; i < 16; i++) rd_chk($sformatf("full_pop_%0d", i), 3'd1, 32'h8000_0022 + 32'(i));
        rd_chk("empty_again", 3'd2, 32'h0001_0000);

        in_port = 8'h40;
        tick();
        tick();
        rd_chk("empty_pushpop", 3'd1, 32'h0000_0000);
        rd_chk("empty_pushpop_status", 3'd2, 32'h0000_0001);
        rd_chk("empty_pushpop_entry", 3'd1, 32'h8000_0040);

`ifdef KEYCODE_IRQ_EN
        wr(3'd3, 32'h0000_0001);
        rd_chk("irqmask_rw", 3'd3, 32'h0000_0001);
        in_port = 8'h1C;
        repeat (3) tick();
        check("irq_at_push", {31'd0, irq}, 32'd0);
        tick();
        check("irq_after_push", {31'd0, irq}, 32'd1);
        rd_chk("irq_pop", 3'd1, 32'h8000_001C);
        check("irq_at_pop", {31'd0, irq}, 32'd1);
        tick();
        check("irq_after_pop", {31'd0, irq}, 32'd0);
        wr(3'd3, 32'h0000_0000);
`else
        wr(3'd3, 32'h0000_0003);
        rd_chk("irqmask_absent", 3'd3, 32'd0);
        set_code(8'h1C);
        check("irq_tied", {31'd0, irq}, 32'd0);
        rd_chk("irq_pop", 3'd1, 32'h8000_001C);
`endif

        for (int i = 1; i <= 5; i++) set_code(8'h50 + 8'(i));
        rd_chk("five_status", 3'd2, 32'h0000_0005);
        rd_chk("five_data", 3'd0, 32'h0000_0055);
        set_code(8'h00);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_readdata", readdata, 32'd0);
        check("midreset_irq", {31'd0, irq}, 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        rd_chk("postreset_status", 3'd2, 32'h0001_0000);
        rd_chk("postreset_fifo", 3'd1, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
